pad_ctrl_array: RTL and testbench
=================================

# pad_ctrl_array

Parametrised pad-control bank between the chip pad ring and the SoC core, replacing per-signal hard-wired OEN/IE tie-offs with runtime-configurable channels. Each of NCH channels provides input synchronisation, an optional glitch filter, input/push-pull/open-drain direction modes and edge-triggered interrupt status. Pad-side outputs drive the IE/OEN/I pins of `pad_io_pd` / `pad_io` cells; core-side signals replace the `gpio_in` / `gpio_out` pairs.

## Interface
- NCH, 32, number of channels (1..64)
- FILT_CYC, 4, stable cycles required by the glitch filter (>=1)
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  config write strobe
- cfg_addr  in  $clog2(NCH) (min 1)  channel index
- cfg_wdata  in  8  [1:0] mode, [2] ie, [3] filt_en, [4] irq_rise_en, [5] irq_fall_en, [7:6] reserved
- out_val  in  NCH  core output value per channel
- in_val  out  NCH  filtered, synchronised pad value to core
- irq_clr  in  NCH  write-1-to-clear for irq_status
- irq_status  out  NCH  latched edge events
- irq_o  out  1  OR of irq_status, registered
- pad_i  in  NCH  raw pad O pin (asynchronous)
- pad_o  out  NCH  to pad I pin
- pad_oen  out  NCH  to pad OEN pin (0 = drive)
- pad_ie  out  NCH  to pad IE pin

## Operation
- Mode: 00 input, 01 push-pull, 10 open-drain, 11 treated as input.
- Input: pad_oen=1, pad_o=0. Push-pull: pad_oen=0, pad_o=out_val. Open-drain: pad_o=0, pad_oen=out_val (drive low on 0, release on 1).
- pad_ie = cfg.ie, in every mode (open-drain readback allowed).
- pad_i passes a 2-flop synchroniser (sync2).
- Unfiltered (filt_en=0): in_val <= sync2 each cycle.
- Filtered: counter increments while sync2 != in_val, clears when equal; in_val toggles on the edge where counter == FILT_CYC-1 and sync2 != in_val, counter then clears. Counter width $clog2(FILT_CYC+1). Pulses shorter than FILT_CYC cycles at sync2 are rejected.
- ie=0: in_val forced to 0, counter cleared.
- Edge detect on in_val vs its previous value, valid only when ie=1 in the current and previous cycle. Rising edge sets irq_status if irq_rise_en; falling edge sets it if irq_fall_en.
- irq_clr bit and set event in the same cycle: set wins.
- cfg_addr >= NCH: write ignored. Config write takes effect the following cycle. Clearing filt_en clears the counter.

## Timing
- Reset: cfg all 0 (input, ie=0), in_val=0, pad_o=0, pad_oen all 1, pad_ie=0, irq_status=0, irq_o=0, sync/filter/edge flops 0.
- Unfiltered latency: in_val changes 2 edges after the edge that first samples the new pad_i. Filtered latency: 1+FILT_CYC edges. FILT_CYC=1 is cycle-identical to unfiltered.
- irq_status sets on the edge after in_val changes. irq_o follows irq_status by 1 cycle.
- pad_o, pad_oen and pad_ie are registered: 1 cycle from out_val or from the config write.
- rst mid-filter or mid-edge discards all state. No event is generated from reset values.

## Structure
- Shared package pad_ctrl_pkg holds:
  - pad_mode_e (PAD_IN, PAD_PP, PAD_OD, PAD_RSV)
  - pad_cfg_t packed struct matching the cfg_wdata layout
  - PAD_CFG_RST constant
- Sub-module pad_ctrl_chan: one channel containing sync, filter, edge detect, irq bit and output regs. Top: config register array with write decode, generate loop over NCH, irq OR and register.

## Test plan
- Reset, then no writes: pad_oen=all 1, pad_ie=0, in_val=0, irq_o=0 regardless of pad_i.
- Ch3 cfg 0x05 (push-pull, ie), out_val[3]=1: pad_oen[3]=0, pad_o[3]=1 one cycle later. Toggle pad_i[3]: in_val[3] follows after 2 edges.
- Ch0 cfg 0x0C, FILT_CYC=4: 3-cycle pad pulse leaves in_val[0]=0. 6-cycle pulse gives in_val[0]=1 at edge 5 after first sample.
- Ch7 cfg 0x16: pad_i rising sets irq_status[7], irq_o=1 one cycle later. irq_clr[7] clears it. Simultaneous clr and new edge leaves it 1.
- Ch1 open-drain (0x06), out_val toggling 0/1: pad_oen toggles 0/1, pad_o stays 0.
- Write with cfg_addr=NCH (NCH=20) leaves all cfg unchanged. rst asserted mid-filter gives reset values on the next edge.

Source files
------------

// File: rtl/pad_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pad_ctrl_pkg
// Shared types for the pad-control bank: direction mode encoding, the per-
// channel configuration byte as a packed struct, its reset value, and the
// helper that maps (mode, core output value) onto the pad I/OEN pins.
// ----------------------------------------------------------------------------
package pad_ctrl_pkg;

  typedef enum logic [1:0] {
    PAD_IN  = 2'b00,
    PAD_PP  = 2'b01,
    PAD_OD  = 2'b10,
    PAD_RSV = 2'b11   // behaves as input
  } pad_mode_e;

  // Field order mirrors cfg_wdata: mode in [1:0] up to reserved in [7:6].
  typedef struct packed {
    logic [1:0] rsvd;
    logic       irq_fall_en;
    logic       irq_rise_en;
    logic       filt_en;
    logic       ie;
    pad_mode_e  mode;
  } pad_cfg_t;

  localparam pad_cfg_t PAD_CFG_RST = '{
    rsvd:        2'b00,
    irq_fall_en: 1'b0,
    irq_rise_en: 1'b0,
    filt_en:     1'b0,
    ie:          1'b0,
    mode:        PAD_IN
  };

  typedef struct packed {
    logic o;    // to pad I pin
    logic oen;  // to pad OEN pin, 0 = drive
  } pad_drv_t;

  // Open-drain drives low only: the core value steers OEN while I stays 0.
  function automatic pad_drv_t pad_drive(input pad_mode_e mode, input logic val);
    pad_drv_t d;
    d = '{o: 1'b0, oen: 1'b1};
    case (mode)
      PAD_PP:  d = '{o: val,  oen: 1'b0};
      PAD_OD:  d = '{o: 1'b0, oen: val};
      default: d = '{o: 1'b0, oen: 1'b1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pad_ctrl_chan.sv
// ----------------------------------------------------------------------------
// pad_ctrl_chan
// One pad channel: 2-flop input synchroniser, optional glitch filter, edge
// detector feeding a sticky interrupt bit, and registered pad outputs.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   cfg_q         current (registered) channel configuration
//   cfg_d         configuration taking effect at the next edge
//   out_val       core output value
//   pad_i         raw asynchronous pad O pin
//   irq_clr       write-1-to-clear for irq_status
//   in_val        filtered, synchronised pad value to the core
//   irq_status    latched edge event
//   pad_o/oen/ie  registered pad I / OEN / IE pins
// ----------------------------------------------------------------------------
module pad_ctrl_chan
  import pad_ctrl_pkg::*;
#(
  parameter int FILT_CYC = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  pad_cfg_t cfg_q,
  input  pad_cfg_t cfg_d,
  input  logic     out_val,
  input  logic     pad_i,
  input  logic     irq_clr,
  output logic     in_val,
  output logic     irq_status,
  output logic     pad_o,
  output logic     pad_oen,
  output logic     pad_ie
);

  localparam int            CW       = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          in_nxt;
  logic          in_prev, ie_prev;
  logic          set_evt, irq_nxt;
  pad_drv_t      drv;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse sync2.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pad_i;
      sync2 <= sync1;
    end
  end

  // Filter: count consecutive cycles where sync2 disagrees with in_val and
  // flip in_val on the FILT_CYC-th one. Any agreement restarts the count.
  // NOTE: both outputs get a default first so no path leaves them unassigned
  // and no latch is inferred.
  always_comb begin
    in_nxt  = in_val;
    cnt_nxt = '0;
    if (!cfg_q.ie) begin
      in_nxt = 1'b0;
    end else if (!cfg_q.filt_en) begin
      in_nxt = sync2;
    end else if (sync2 != in_val) begin
      if (cnt == CNT_LAST) in_nxt  = sync2;
      else                 cnt_nxt = cnt + 1'b1;
    end
  end

  // Edges only count when ie was set on both sides of the transition, so
  // enabling or disabling a channel never fakes an event.
  always_comb begin
    set_evt = 1'b0;
    if (cfg_q.ie && ie_prev) begin
      if ( in_val && !in_prev && cfg_q.irq_rise_en) set_evt = 1'b1;
      if (!in_val &&  in_prev && cfg_q.irq_fall_en) set_evt = 1'b1;
    end
    // A new event in the same cycle as a clear keeps the bit set.
    irq_nxt = set_evt | (irq_status & ~irq_clr);
  end

  // Outputs are built from cfg_d so they land one edge after a config write.
  assign drv = pad_drive(cfg_d.mode, out_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      in_val     <= 1'b0;
      in_prev    <= 1'b0;
      ie_prev    <= 1'b0;
      irq_status <= 1'b0;
      pad_o      <= 1'b0;
      pad_oen    <= 1'b1;
      pad_ie     <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      in_val     <= in_nxt;
      in_prev    <= in_val;
      ie_prev    <= cfg_q.ie;
      irq_status <= irq_nxt;
      pad_o      <= drv.o;
      pad_oen    <= drv.oen;
      pad_ie     <= cfg_d.ie;
    end
  end

endmodule

// File: rtl/pad_ctrl_array.sv
// ----------------------------------------------------------------------------
// pad_ctrl_array
// Bank of NCH runtime-configurable pad channels between the pad ring and the
// SoC core. Holds the per-channel configuration registers, decodes writes,
// and combines the channel interrupt bits into a registered irq_o.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   cfg_we       configuration write strobe
//   cfg_addr     channel index; indices >= NCH are ignored
//   cfg_wdata    [1:0] mode, [2] ie, [3] filt_en, [4] irq_rise_en,
//                [5] irq_fall_en, [7:6] reserved
//   out_val      core output value per channel
//   in_val       filtered, synchronised pad value per channel
//   irq_clr      write-1-to-clear per channel
//   irq_status   latched edge events
//   irq_o        registered OR of irq_status
//   pad_i        raw pad O pins (asynchronous)
//   pad_o        to pad I pins
//   pad_oen      to pad OEN pins (0 = drive)
//   pad_ie       to pad IE pins
// ----------------------------------------------------------------------------
module pad_ctrl_array
  import pad_ctrl_pkg::*;
#(
  parameter  int NCH      = 32,
  parameter  int FILT_CYC = 4,
  localparam int AW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [7:0]     cfg_wdata,
  input  logic [NCH-1:0] out_val,
  output logic [NCH-1:0] in_val,
  input  logic [NCH-1:0] irq_clr,
  output logic [NCH-1:0] irq_status,
  output logic           irq_o,
  input  logic [NCH-1:0] pad_i,
  output logic [NCH-1:0] pad_o,
  output logic [NCH-1:0] pad_oen,
  output logic [NCH-1:0] pad_ie
);

  pad_cfg_t cfg_q [NCH];
  pad_cfg_t cfg_d [NCH];

  // Compare against each legal index rather than indexing the array, so an
  // out-of-range address simply matches nothing.
  always_comb begin
    cfg_d = cfg_q;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_we && (cfg_addr == AW'(i))) cfg_d[i] = pad_cfg_t'(cfg_wdata);
    end
  end

  // NOTE: the config array is a handful of flops, not a RAM, so it is reset
  // element by element to guarantee every pad comes up as a plain input.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cfg_q[i] <= PAD_CFG_RST;
    end else begin
      cfg_q <= cfg_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    pad_ctrl_chan #(
      .FILT_CYC (FILT_CYC)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .cfg_q      (cfg_q[g]),
      .cfg_d      (cfg_d[g]),
      .out_val    (out_val[g]),
      .pad_i      (pad_i[g]),
      .irq_clr    (irq_clr[g]),
      .in_val     (in_val[g]),
      .irq_status (irq_status[g]),
      .pad_o      (pad_o[g]),
      .pad_oen    (pad_oen[g]),
      .pad_ie     (pad_ie[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) irq_o <= 1'b0;
    else     irq_o <= |irq_status;
  end

endmodule

// File: tb/tb_pad_ctrl_array.sv
// ----------------------------------------------------------------------------
// tb_pad_ctrl_array
// Directed self-checking bench for pad_ctrl_array with NCH=20, FILT_CYC=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_pad_ctrl_array;

  localparam int NCH      = 20;
  localparam int FILT_CYC = 4;
  localparam int AW       = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_we;
  logic [AW-1:0]  cfg_addr;
  logic [7:0]     cfg_wdata;
  logic [NCH-1:0] out_val;
  logic [NCH-1:0] in_val;
  logic [NCH-1:0] irq_clr;
  logic [NCH-1:0] irq_status;
  logic           irq_o;
  logic [NCH-1:0] pad_i;
  logic [NCH-1:0] pad_o;
  logic [NCH-1:0] pad_oen;
  logic [NCH-1:0] pad_ie;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pad_ctrl_array #(
    .NCH      (NCH),
    .FILT_CYC (FILT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .out_val    (out_val),
    .in_val     (in_val),
    .irq_clr    (irq_clr),
    .irq_status (irq_status),
    .irq_o      (irq_o),
    .pad_i      (pad_i),
    .pad_o      (pad_o),
    .pad_oen    (pad_oen),
    .pad_ie     (pad_ie)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [7:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  logic seen_hi;

  initial begin
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    out_val   = '0;
    irq_clr   = '0;
    pad_i     = 20'hA5A5A;
    tick(2);
    rst = 1'b0;

    // Reset state, and no channel passes pad_i while ie=0.
    check("rst_oen",  32'(pad_oen),    32'h000F_FFFF);
    check("rst_ie",   32'(pad_ie),     32'h0);
    check("rst_o",    32'(pad_o),      32'h0);
    check("rst_in",   32'(in_val),     32'h0);
    check("rst_irqs", 32'(irq_status), 32'h0);
    check("rst_irqo", 32'(irq_o),      32'h0);
    pad_i = 20'hFFFFF;
    tick(5);
    check("noie_in",  32'(in_val),     32'h0);
    check("noie_oen", 32'(pad_oen),    32'h000F_FFFF);
    pad_i = '0;
    tick(3);

    // Ch3 push-pull with ie; outputs land one edge after the write.
    out_val[3] = 1'b1;
    cfg_write(5'd3, 8'h05);
    check("pp_oen3", 32'(pad_oen[3]), 32'h0);
    check("pp_o3",   32'(pad_o[3]),   32'h1);
    check("pp_ie3",  32'(pad_ie[3]),  32'h1);
    tick(2);
    pad_i[3] = 1'b1;
    tick();  check("sync_e1", 32'(in_val[3]), 32'h0);
    tick();  check("sync_e2", 32'(in_val[3]), 32'h0);
    tick();  check("sync_e3", 32'(in_val[3]), 32'h1);
    pad_i[3] = 1'b0;
    tick(2); check("sync_f2", 32'(in_val[3]), 32'h1);
    tick();  check("sync_f3", 32'(in_val[3]), 32'h0);
    check("pp_noirq", 32'(irq_status[3]), 32'h0);

    // Ch0 filtered: a 3-cycle pulse is rejected.
    cfg_write(5'd0, 8'h0C);
    tick(2);
    seen_hi  = 1'b0;
    pad_i[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (in_val[0]) seen_hi = 1'b1;
    end
    pad_i[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (in_val[0]) seen_hi = 1'b1;
    end
    check("filt_short", 32'(seen_hi), 32'h0);

    // 6-cycle pulse: in_val rises 5 edges after the first sampling edge.
    pad_i[0] = 1'b1;
    tick(5); check("filt_e5", 32'(in_val[0]), 32'h0);
    tick();  check("filt_e6", 32'(in_val[0]), 32'h1);
    pad_i[0] = 1'b0;
    tick(5); check("filt_f5", 32'(in_val[0]), 32'h1);
    tick();  check("filt_f6", 32'(in_val[0]), 32'h0);

    // Ch7 open-drain, ie, rise interrupt.
    cfg_write(5'd7, 8'h16);
    tick(3);
    pad_i[7] = 1'b1;
    tick(3); check("irq_e3",   32'(irq_status[7]), 32'h0);
             check("irq_in7",  32'(in_val[7]),     32'h1);
    tick();  check("irq_e4",   32'(irq_status[7]), 32'h1);
             check("irqo_e4",  32'(irq_o),         32'h0);
    tick();  check("irqo_e5",  32'(irq_o),         32'h1);
    irq_clr[7] = 1'b1;
    tick();  check("irq_clr",  32'(irq_status[7]), 32'h0);
    irq_clr[7] = 1'b0;
    tick();  check("irqo_clr", 32'(irq_o),         32'h0);
    pad_i[7] = 1'b0;  // falling edge, not enabled
    tick(5); check("irq_nofall", 32'(irq_status[7]), 32'h0);
    pad_i[7] = 1'b1;
    tick(3);
    irq_clr[7] = 1'b1;  // clear coincides with the set event
    tick();  check("irq_setwins", 32'(irq_status[7]), 32'h1);
    irq_clr[7] = 1'b0;
    tick();  check("irq_hold", 32'(irq_status[7]), 32'h1);

    // Ch1 open-drain: OEN follows out_val, I stays 0.
    cfg_write(5'd1, 8'h06);
    tick();  check("od_oen0", 32'(pad_oen[1]), 32'h0);
             check("od_o0",   32'(pad_o[1]),   32'h0);
    out_val[1] = 1'b1;
    tick();  check("od_oen1", 32'(pad_oen[1]), 32'h1);
             check("od_o1",   32'(pad_o[1]),   32'h0);
    out_val[1] = 1'b0;
    tick();  check("od_oen2", 32'(pad_oen[1]), 32'h0);

    // Ch2 mode 11 behaves as input even with out_val high.
    out_val[2] = 1'b1;
    cfg_write(5'd2, 8'h07);
    check("rsv_oen", 32'(pad_oen[2]), 32'h1);
    check("rsv_o",   32'(pad_o[2]),   32'h0);
    check("rsv_ie",  32'(pad_ie[2]),  32'h1);

    // Out-of-range address changes nothing (and must not alias to ch4).
    // ie on ch0,1,2,3,7; drivers: ch3 PP, ch1 OD low, ch7 OD low.
    cfg_write(5'd20, 8'h05);
    tick();
    check("oob_ie",  32'(pad_ie),  32'h0000_008F);
    check("oob_oen", 32'(pad_oen), 32'h000F_FF75);
    check("oob_o",   32'(pad_o),   32'h0000_0008);

    // Reset in the middle of a filter run discards everything.
    pad_i[0] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick();
    check("mrst_oen",  32'(pad_oen),    32'h000F_FFFF);
    check("mrst_ie",   32'(pad_ie),     32'h0);
    check("mrst_o",    32'(pad_o),      32'h0);
    check("mrst_in",   32'(in_val),     32'h0);
    check("mrst_irqs", 32'(irq_status), 32'h0);
    rst = 1'b0;
    tick(6);
    check("post_in",   32'(in_val),     32'h0);
    check("post_irqs", 32'(irq_status), 32'h0);
    check("post_irqo", 32'(irq_o),      32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
